cpumc_arb: RTL
==============

# cpumc_arb

CPU memory-bus arbiter for the NES top level. It shares the single CPU-side memory bus (cart PRG, WRAM, PPU registers, joypad) between the 6502 core and three bus masters: the serial debugger, the APU DMC sample DMA and the sprite DMA. It replaces the ad-hoc combinational priority mux with a registered grant state machine. The state machine halts the CPU through READY, waits for a safe halt point, hands the bus to exactly one master, and returns it cleanly.

## Interface
Parameters: none.

Ports (name, direction, width, meaning):
- clk_in  input  1  system clock (50 MHz); all state changes on its rising edge
- nrst_in  input  1  reset, asynchronous, active-low
- cpu_a_in  input  16  CPU address
- cpu_r_nw_in  input  1  CPU R/!W
- cpu_d_in  input  8  CPU write data
- dbg_req_in  input  1  debugger bus request; level, held for entire ownership
- dbg_a_in / dbg_r_nw_in / dbg_d_in  input  16/1/8  debugger bus signals
- dmc_req_in  input  1  DMC DMA request; level
- dmc_a_in  input  16  DMC read address; DMC is read-only
- dma_req_in  input  1  sprite DMA request; level
- dma_a_in / dma_r_nw_in / dma_d_in  input  16/1/8  sprite DMA bus signals
- cpu_ready_out  output  1  CPU READY; 0 halts the CPU
- dbg_gnt_out / dmc_gnt_out / dma_gnt_out  output  1 each  registered grants, one-hot or all zero
- bus_a_out / bus_r_nw_out / bus_d_out  output  16/1/8  arbitrated memory-bus signals
- owner_out  output  2  0 = CPU, 1 = dbg, 2 = dmc, 3 = sprite DMA

## Operation
- States: RUN, STALL, GRANT, HANDOFF. An owner register holds the current owner (2 bits).
- Priority is fixed: dbg > dmc > sprite DMA. The owner is chosen at the edge that enters GRANT, not at the edge where the request first appeared.
- RUN: cpu_ready_out=1 and the bus passes the CPU signals through. If any request is high at the edge, go to STALL.
- STALL: cpu_ready_out=0 and the bus still passes the CPU signals. The 6502 only halts on a read cycle, so it may finish up to 3 writes here.
  - At each edge, if all requests are low, return to RUN.
  - Otherwise, if cpu_r_nw_in=1, go to GRANT with the highest-priority pending owner.
  - Otherwise, stay in STALL. There is no timeout.
- GRANT: the owner's gnt=1 and cpu_ready_out=0. The bus is muxed combinationally from the owner's inputs.
  - When DMC owns: bus_r_nw_out=1 and bus_d_out=0.
  - No preemption: the owner keeps the bus until its req drops, even if a higher-priority request arrives.
  - At the edge where the owner's req is sampled low: if another req is high, go to HANDOFF; otherwise go to RUN.
- HANDOFF: one cycle with all gnts=0 and cpu_ready_out=0. The bus carries cpu_a_in with bus_r_nw_out=1 and bus_d_out=0, i.e. a dummy read with no write possible.
  - At the next edge, go to GRANT with the highest pending requester.
  - If none is pending, go to RUN.
- Invariant: at most one gnt is high at a time, and the bus is never driven as a write unless it comes from the current owner or from the CPU in RUN/STALL.

## Timing
- Reset (nrst_in=0, takes effect immediately) and the values held until the first edge after release:
  - state=RUN, owner_out=0, cpu_ready_out=1, all gnts=0
  - bus_a_out/bus_r_nw_out/bus_d_out follow the CPU inputs
- Reset mid-GRANT: the grant drops asynchronously. The master must tolerate losing the bus.
- Request to grant, minimum: req high before edge k → cpu_ready_out=0 after edge k. If cpu_r_nw_in=1 at edge k+1, gnt=1 after edge k+1, a latency of 2 cycles. Each CPU write cycle sampled in STALL adds 1 cycle.
- Release: owner req low at edge m → gnt=0 after edge m.
  - No other requests: cpu_ready_out=1 after edge m.
  - Another request pending: HANDOFF during cycle m+1, and the new gnt is high after edge m+1.
- All outputs except the bus mux are registered. The bus mux is combinational from registered state/owner plus the current-cycle inputs.
- Simultaneous requests: the tie is resolved by priority at the GRANT-entry edge. A lower-priority master that requested first can lose to a later higher-priority master.
- Request dropped in STALL before the grant: RUN after that edge, with no grant pulse.

## Test plan
- Reset: hold nrst_in=0 with cpu_a_in=0x8000 → cpu_ready_out=1, gnts=000, owner_out=0, bus_a_out=0x8000. Release reset → state remains RUN.
- Sprite DMA while CPU reads: dma_req=1 at edge 0 with cpu_r_nw=1 → ready=0 after edge 0, dma_gnt=1 after edge 1. Set dma_a=0x0200, dma_r_nw=0, dma_d=0x5A → bus_a_out=0x0200, bus_r_nw_out=0, bus_d_out=0x5A.
- CPU write stall: dbg_req=1 while the CPU issues 3 write cycles (cpu_r_nw=0) → STALL for 3 cycles, dbg_gnt=1 exactly 1 cycle after the first read sample, with no gnt during the writes.
- Simultaneous and handoff: dma_req and dmc_req rise together → dmc_gnt first. Drop dmc_req → one HANDOFF cycle with bus_r_nw_out=1 and all gnts 0, then dma_gnt=1. Drop dma_req → ready=1 the next cycle.
- No preemption: while dma owns, raise dbg_req → dma_gnt stays high. When dma_req drops → HANDOFF, then dbg_gnt=1.
- Abort and reset: dma_req pulses for 1 cycle during a CPU write → return to RUN with no gnt. Assert nrst_in=0 mid-GRANT → gnt=0 and ready=1 immediately.

Source files
------------

// File: rtl/cpumc_arb.sv
// CPU memory-bus arbiter: halts the 6502 via READY and hands the shared
// bus to one of debugger, DMC DMA or sprite DMA with fixed priority.
module cpumc_arb (
    input  logic        clk_in,
    input  logic        nrst_in,
    input  logic [15:0] cpu_a_in,
    input  logic        cpu_r_nw_in,
    input  logic [7:0]  cpu_d_in,
    input  logic        dbg_req_in,
    input  logic [15:0] dbg_a_in,
    input  logic        dbg_r_nw_in,
    input  logic [7:0]  dbg_d_in,
    input  logic        dmc_req_in,
    input  logic [15:0] dmc_a_in,
    input  logic        dma_req_in,
    input  logic [15:0] dma_a_in,
    input  logic        dma_r_nw_in,
    input  logic [7:0]  dma_d_in,
    output logic        cpu_ready_out,
    output logic        dbg_gnt_out,
    output logic        dmc_gnt_out,
    output logic        dma_gnt_out,
    output logic [15:0] bus_a_out,
    output logic        bus_r_nw_out,
    output logic [7:0]  bus_d_out,
    output logic [1:0]  owner_out
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        STALL   = 2'd1,
        GRANT   = 2'd2,
        HANDOFF = 2'd3
    } state_t;

    localparam logic [1:0] OWN_CPU = 2'd0;
    localparam logic [1:0] OWN_DBG = 2'd1;
    localparam logic [1:0] OWN_DMC = 2'd2;
    localparam logic [1:0] OWN_DMA = 2'd3;

    state_t     state;
    state_t     state_nxt;
    logic [1:0] owner;
    logic [1:0] owner_nxt;
    logic       any_req;
    logic       owner_req;
    logic [1:0] pick;

    // Fixed priority selection of the winning requester
    always_comb begin
        any_req = dbg_req_in | dmc_req_in | dma_req_in;
        if (dbg_req_in)
            pick = OWN_DBG;
        else if (dmc_req_in)
            pick = OWN_DMC;
        else if (dma_req_in)
            pick = OWN_DMA;
        else
            pick = OWN_CPU;
    end

    // Request level of the master currently holding the bus
    always_comb begin
        unique case (owner)
            OWN_DBG: owner_req = dbg_req_in;
            OWN_DMC: owner_req = dmc_req_in;
            OWN_DMA: owner_req = dma_req_in;
            default: owner_req = 1'b0;
        endcase
    end

    // State and owner registers; owner is CPU outside GRANT
    always_ff @(posedge clk_in or negedge nrst_in) begin
        if (!nrst_in) begin
            state <= RUN;
            owner <= OWN_CPU;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
        end
    end

    // Next-state logic: halt, wait for a read cycle, grant, release
    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        unique case (state)
            RUN: begin
                if (any_req)
                    state_nxt = STALL;
            end
            STALL: begin
                if (!any_req) begin
                    state_nxt = RUN;
                end else if (cpu_r_nw_in) begin
                    state_nxt = GRANT;
                    owner_nxt = pick;
                end
            end
            GRANT: begin
                if (!owner_req) begin
                    state_nxt = any_req ? HANDOFF : RUN;
                    owner_nxt = OWN_CPU;
                end
            end
            HANDOFF: begin
                if (any_req) begin
                    state_nxt = GRANT;
                    owner_nxt = pick;
                end else begin
                    state_nxt = RUN;
                end
            end
            default: begin
                state_nxt = RUN;
                owner_nxt = OWN_CPU;
            end
        endcase
    end

    // Outputs: grants and READY from registers, bus mux from owner
    always_comb begin
        cpu_ready_out = (state == RUN);
        dbg_gnt_out   = (state == GRANT) && (owner == OWN_DBG);
        dmc_gnt_out   = (state == GRANT) && (owner == OWN_DMC);
        dma_gnt_out   = (state == GRANT) && (owner == OWN_DMA);
        owner_out     = owner;
        bus_a_out     = cpu_a_in;
        bus_r_nw_out  = cpu_r_nw_in;
        bus_d_out     = cpu_d_in;
        if (state == HANDOFF) begin
            bus_r_nw_out = 1'b1;
            bus_d_out    = 8'h00;
        end else if (state == GRANT) begin
            unique case (owner)
                OWN_DBG: begin
                    bus_a_out    = dbg_a_in;
                    bus_r_nw_out = dbg_r_nw_in;
                    bus_d_out    = dbg_d_in;
                end
                OWN_DMC: begin
                    bus_a_out    = dmc_a_in;
                    bus_r_nw_out = 1'b1;
                    bus_d_out    = 8'h00;
                end
                OWN_DMA: begin
                    bus_a_out    = dma_a_in;
                    bus_r_nw_out = dma_r_nw_in;
                    bus_d_out    = dma_d_in;
                end
                default: begin
                    bus_r_nw_out = 1'b1;
                    bus_d_out    = 8'h00;
                end
            endcase
        end
    end

endmodule
